instr_queue: RTL and testbench
==============================

INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of entry count (16 entries).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rdy  input  1  global ready; low freezes all state.
REQ-005 SHALL have port flush  input  1  misprediction clear from ROB.
REQ-006 SHALL have ports in_valid/in_optype/in_inst/in_pc/in_pred_jump  input  1/6/32/32/1  decoded instruction from fetch.
REQ-007 SHALL have port in_ready  output  1  queue can accept a push this cycle.
REQ-008 SHALL have ports ROB_full/RS_full/LSB_full  input  1 each  downstream occupancy, as seen by the dispatcher.
REQ-009 SHALL have ports out_valid/out_optype/out_inst/out_pc/out_pred_jump  output  1/6/32/32/1  queue head toward the dispatcher (ifetch_valid/ifetch_optype).
REQ-010 SHALL have port count  output  DEPTH_LOG2+1  current occupancy.

Function
REQ-011 SHALL be a circular FIFO: head and tail pointers of DEPTH_LOG2 bits with natural wrap-around, plus an occupancy counter of DEPTH_LOG2+1 bits.
REQ-012 in_ready SHALL equal (count != 2^DEPTH_LOG2); it is combinational from state only.
REQ-013 push SHALL equal rdy & in_valid & in_ready & ~flush; in_* are written at tail, and tail increments.
REQ-014 out_valid SHALL equal (count != 0); out_* SHALL be the head entry, combinational from storage.
REQ-015 is_ls SHALL be (out_optype >= LB && out_optype <= SW); pop SHALL equal rdy & out_valid & ~ROB_full & (is_ls ? ~LSB_full : ~RS_full) & ~flush.
REQ-016 pop SHALL increment head; count SHALL update by +push-pop, so simultaneous push and pop leave count unchanged.
REQ-017 Push latency SHALL be 1 cycle: an entry pushed at edge N is visible on out_* after edge N.
REQ-018 When full, in_valid SHALL be ignored and no entry is overwritten; a same-cycle pop does not enable a push (in_ready stays low).
REQ-019 When empty, pop SHALL be 0 and out_* values are don't-care.
REQ-020 flush SHALL take priority: on the next edge head=tail=0 and count=0, and push/pop are suppressed.
REQ-021 When rdy=0, pointers, count and storage SHALL hold; outputs continue to reflect the held state.

Reset
REQ-022 While rst=0 (asynchronously): head=0, tail=0, count=0, out_valid=0, in_ready=1; storage contents are not reset.
REQ-023 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-024 Macro IQ_BYPASS_EN SHALL select a bypass path; when it is not defined, behaviour is exactly REQ-011..REQ-021.
REQ-025 With IQ_BYPASS_EN defined and count==0, the input SHALL pass straight through: out_valid=in_valid&~flush and out_*=in_* in the same cycle.
REQ-026 Under bypass, if pop is asserted the entry is consumed without a write (count stays 0); otherwise it is pushed normally.

Structure
REQ-027 Optype encodings (LB..SW and the rest), True/False and ROBRange SHALL come from the shared defines.v; no local redefinition.
REQ-028 Storage SHALL be an inline register array; no sub-module is needed.

Verification
REQ-029 Push 3 entries (pc 0x0,0x4,0x8), all full flags=0 -> out_pc shows 0x0, 0x4, 0x8 on consecutive cycles; count returns to 0.
REQ-030 Push 16 entries with ROB_full=1 -> count=16, in_ready=0; a 17th push is dropped; after ROB_full=0, 16 pops occur in order.
REQ-031 Head is optype LW with LSB_full=1 and RS_full=0 -> no pop; head is ADD with RS_full=1 -> no pop; clearing each flag pops the head.
REQ-032 count=5 and flush with in_valid=1 -> after the edge count=0 and out_valid=0; the flushed-cycle input is not stored.
REQ-033 rst pulled low between edges with count=7 -> out_valid=0 and count=0 immediately; rdy=0 for 4 cycles with in_valid=1 -> count is unchanged.
REQ-034 With IQ_BYPASS_EN, empty queue, in_valid=1 with pc 0x40 and no full flags -> out_valid=1 and out_pc=0x40 in the same cycle; count stays 0.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// Shared instruction-queue definitions: optype encodings, boolean and ROB-range
// constants, the stored entry layout and the load/store classifier.
package instr_queue_pkg;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    localparam int unsigned ROBRange = 16;

    localparam logic [5:0] NOP   = 6'd0;
    localparam logic [5:0] LUI   = 6'd1;
    localparam logic [5:0] AUIPC = 6'd2;
    localparam logic [5:0] JAL   = 6'd3;
    localparam logic [5:0] JALR  = 6'd4;
    localparam logic [5:0] BEQ   = 6'd5;
    localparam logic [5:0] BNE   = 6'd6;
    localparam logic [5:0] BLT   = 6'd7;
    localparam logic [5:0] BGE   = 6'd8;
    localparam logic [5:0] BLTU  = 6'd9;
    localparam logic [5:0] BGEU  = 6'd10;
    localparam logic [5:0] LB    = 6'd11;
    localparam logic [5:0] LH    = 6'd12;
    localparam logic [5:0] LW    = 6'd13;
    localparam logic [5:0] LBU   = 6'd14;
    localparam logic [5:0] LHU   = 6'd15;
    localparam logic [5:0] SB    = 6'd16;
    localparam logic [5:0] SH    = 6'd17;
    localparam logic [5:0] SW    = 6'd18;
    localparam logic [5:0] ADDI  = 6'd19;
    localparam logic [5:0] SLTI  = 6'd20;
    localparam logic [5:0] SLTIU = 6'd21;
    localparam logic [5:0] XORI  = 6'd22;
    localparam logic [5:0] ORI   = 6'd23;
    localparam logic [5:0] ANDI  = 6'd24;
    localparam logic [5:0] SLLI  = 6'd25;
    localparam logic [5:0] SRLI  = 6'd26;
    localparam logic [5:0] SRAI  = 6'd27;
    localparam logic [5:0] ADD   = 6'd28;
    localparam logic [5:0] SUB   = 6'd29;
    localparam logic [5:0] SLL   = 6'd30;
    localparam logic [5:0] SLT   = 6'd31;
    localparam logic [5:0] SLTU  = 6'd32;
    localparam logic [5:0] XOR   = 6'd33;
    localparam logic [5:0] SRL   = 6'd34;
    localparam logic [5:0] SRA   = 6'd35;
    localparam logic [5:0] OR    = 6'd36;
    localparam logic [5:0] AND   = 6'd37;

    typedef struct packed {
        logic [5:0]  optype;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred_jump;
    } iq_entry_t;

    // Loads and stores dispatch to the LSB, everything else to the RS.
    function automatic logic is_ls(input logic [5:0] optype);
        return (optype >= LB) && (optype <= SW);
    endfunction

endpackage

// File: rtl/instr_queue.sv
// Circular instruction queue between fetch/decode and the dispatcher.
// Optional same-cycle bypass on an empty queue is enabled by defining IQ_BYPASS_EN.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [5:0]            in_optype,
    input  logic [31:0]           in_inst,
    input  logic [31:0]           in_pc,
    input  logic                  in_pred_jump,
    output logic                  in_ready,
    input  logic                  ROB_full,
    input  logic                  RS_full,
    input  logic                  LSB_full,
    output logic                  out_valid,
    output logic [5:0]            out_optype,
    output logic [31:0]           out_inst,
    output logic [31:0]           out_pc,
    output logic                  out_pred_jump,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;
    iq_entry_t             mem [DEPTH];

    iq_entry_t in_entry;
    iq_entry_t out_entry;
    logic      empty;
    logic      push;
    logic      pop;
    logic      consume;

    assign in_entry = '{optype: in_optype, inst: in_inst, pc: in_pc, pred_jump: in_pred_jump};
    assign empty    = (count == '0);
    assign in_ready = (count != FULL_COUNT);

    always_comb begin
        out_entry = mem[head];
        out_valid = !empty;
`ifdef IQ_BYPASS_EN
        if (empty) begin
            out_entry = in_entry;
            out_valid = in_valid & ~flush;
        end
`endif
        pop = rdy & out_valid & ~ROB_full
            & (is_ls(out_entry.optype) ? ~LSB_full : ~RS_full) & ~flush;
        push = rdy & in_valid & in_ready & ~flush;
        // A bypassed entry that is dispatched at once never touches storage.
        if (empty && pop) begin
            push = 1'b0;
        end
        consume = pop & ~empty;
    end

    assign out_optype    = out_entry.optype;
    assign out_inst      = out_entry.inst;
    assign out_pc        = out_entry.pc;
    assign out_pred_jump = out_entry.pred_jump;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy && flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (consume) begin
                head <= head + 1'b1;
            end
            count <= count + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, consume};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= in_entry;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: accepted pushes enter a model queue,
// dispatches retire its head, and each scenario compares the DUT against it.
module tb_instr_queue;
    import instr_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        in_valid;
    logic [5:0]  in_optype;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_pred_jump;
    logic        in_ready;
    logic        ROB_full;
    logic        RS_full;
    logic        LSB_full;
    logic        out_valid;
    logic [5:0]  out_optype;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_pred_jump;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    iq_entry_t sb[$];

    always #5 clk = ~clk;

    instr_queue #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_optype(in_optype), .in_inst(in_inst),
        .in_pc(in_pc), .in_pred_jump(in_pred_jump), .in_ready(in_ready),
        .ROB_full(ROB_full), .RS_full(RS_full), .LSB_full(LSB_full),
        .out_valid(out_valid), .out_optype(out_optype), .out_inst(out_inst),
        .out_pc(out_pc), .out_pred_jump(out_pred_jump), .count(count)
    );

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] pc);
        in_valid     = v;
        in_optype    = op;
        in_pc        = pc;
        in_inst      = pc ^ 32'hA5A5_0000;
        in_pred_jump = pc[2];
    endtask

    // Advance one clock and update the scoreboard with what the queue should have done.
    task automatic cycle();
        iq_entry_t cur;
        iq_entry_t hd;
        logic      m_empty;
        logic      m_valid;
        logic      m_ls;
        logic      m_push;
        logic      m_pop;
        cur = '{optype: in_optype, inst: in_inst, pc: in_pc, pred_jump: in_pred_jump};
        m_empty = (sb.size() == 0);
        hd = m_empty ? cur : sb[0];
        m_valid = !m_empty;
`ifdef IQ_BYPASS_EN
        if (m_empty) m_valid = in_valid & ~flush;
`endif
        m_ls   = (hd.optype >= 6'd11) && (hd.optype <= 6'd18);
        m_pop  = rdy & m_valid & ~ROB_full & (m_ls ? ~LSB_full : ~RS_full) & ~flush;
        m_push = rdy & in_valid & (sb.size() < 16) & ~flush & ~(m_empty & m_pop);
        @(posedge clk);
        #1;
        if (rdy && flush) begin
            sb.delete();
        end else begin
            if (m_pop && !m_empty) void'(sb.pop_front());
            if (m_push) sb.push_back(cur);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        ROB_full = 1'b0; RS_full = 1'b0; LSB_full = 1'b0;
        drive(1'b0, ADD, 32'h0);
        #3;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fifo_order();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ADD, 32'(i * 4));
            cycle();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || sb.size() == 0 || out_pc !== sb[0].pc) begin
                errors++; $display("FAIL order_pc%0d got v=%b pc=%h want pc=%h", i, out_valid, out_pc, i * 4);
            end
            checks++;
            if (sb.size() > 0 && (out_inst !== sb[0].inst || out_pred_jump !== sb[0].pred_jump)) begin
                errors++; $display("FAIL order_fields%0d got inst=%h pj=%b want inst=%h pj=%b",
                                   i, out_inst, out_pred_jump, sb[0].inst, sb[0].pred_jump);
            end
        end
        drive(1'b0, ADD, 32'h0);
        cycle();
        checks++;
        if (count !== 5'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL order_drain got count=%0d v=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_full();
        ROB_full = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, ADD, 32'h100 + 32'(i * 4));
            cycle();
        end
        checks++;
        if (count !== 5'd16 || in_ready !== 1'b0) begin
            errors++; $display("FAIL full_state got count=%0d rdy=%b want 16/0", count, in_ready);
        end
        drive(1'b1, ADD, 32'h1FC);
        cycle();
        checks++;
        if (count !== 5'd16 || out_pc !== 32'h100) begin
            errors++; $display("FAIL full_drop got count=%0d pc=%h want 16/00000100", count, out_pc);
        end
        ROB_full = 1'b0;
        drive(1'b1, ADD, 32'h200);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (sb.size() == 0 || out_pc !== sb[0].pc || out_pc !== 32'h100 + 32'(i * 4)) begin
                errors++; $display("FAIL full_pop%0d got pc=%h want %h", i, out_pc, 32'h100 + 32'(i * 4));
            end
            cycle();
            drive(1'b0, ADD, 32'h0);
            if (i == 0) begin
                checks++;
                if (count !== 5'd15) begin errors++; $display("FAIL full_pop_no_push got count=%0d want 15", count); end
            end
        end
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL full_empty got count=%0d want 0", count); end
    endtask

    task automatic test_dispatch_stall();
        logic [5:0] ops [4];
        ops[0] = LB; ops[1] = SW; ops[2] = BGEU; ops[3] = ADDI;
        ROB_full = 1'b1;
        drive(1'b1, LW, 32'h300); cycle();
        drive(1'b1, ADD, 32'h304); cycle();
        drive(1'b0, ADD, 32'h0);
        ROB_full = 1'b0; LSB_full = 1'b1; RS_full = 1'b0;
        cycle();
        checks++;
        if (count !== 5'd2 || out_optype !== LW) begin
            errors++; $display("FAIL stall_lw got count=%0d op=%0d want 2/%0d", count, out_optype, LW);
        end
        LSB_full = 1'b0; RS_full = 1'b1;
        cycle();
        checks++;
        if (count !== 5'd1 || out_optype !== ADD || out_pc !== 32'h304) begin
            errors++; $display("FAIL stall_lw_pop got count=%0d op=%0d want 1/%0d", count, out_optype, ADD);
        end
        cycle();
        checks++;
        if (count !== 5'd1) begin errors++; $display("FAIL stall_add got count=%0d want 1", count); end
        RS_full = 1'b0;
        cycle();
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL stall_add_pop got count=%0d want 0", count); end
        // Classification edges: only LB..SW wait on the LSB.
        for (int i = 0; i < 4; i++) begin
            ROB_full = 1'b1;
            drive(1'b1, ops[i], 32'h380 + 32'(i * 4)); cycle();
            drive(1'b0, ADD, 32'h0);
            ROB_full = 1'b0; LSB_full = 1'b1; RS_full = 1'b0;
            cycle();
            checks++;
            if (count !== 5'(sb.size()) || count !== ((i < 2) ? 5'd1 : 5'd0)) begin
                errors++; $display("FAIL stall_class_op%0d got count=%0d want %0d", ops[i], count, (i < 2) ? 1 : 0);
            end
            LSB_full = 1'b0;
            cycle();
        end
    endtask

    task automatic test_flush();
        ROB_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ADD, 32'h400 + 32'(i * 4)); cycle();
        end
        checks++;
        if (count !== 5'd5) begin errors++; $display("FAIL flush_fill got count=%0d want 5", count); end
        flush = 1'b1;
        drive(1'b1, ADD, 32'h500);
        cycle();
        flush = 1'b0;
        drive(1'b0, ADD, 32'h0);
        #1;
        checks++;
        if (count !== 5'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_clear got count=%0d v=%b want 0/0", count, out_valid);
        end
        ROB_full = 1'b0;
        cycle();
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL flush_not_stored got count=%0d want 0", count); end
        ROB_full = 1'b1;
        drive(1'b1, SUB, 32'h504); cycle();
        drive(1'b0, ADD, 32'h0);
        checks++;
        if (sb.size() == 0 || out_pc !== sb[0].pc || out_optype !== SUB) begin
            errors++; $display("FAIL flush_restart got pc=%h op=%0d want 00000504/%0d", out_pc, out_optype, SUB);
        end
        ROB_full = 1'b0;
        cycle();
    endtask

    task automatic test_async_reset_and_rdy();
        ROB_full = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ADD, 32'h600 + 32'(i * 4)); cycle();
        end
        drive(1'b0, ADD, 32'h0);
        checks++;
        if (count !== 5'd7) begin errors++; $display("FAIL areset_fill got count=%0d want 7", count); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 5'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL areset_immediate got v=%b count=%0d rdy=%b want 0/0/1", out_valid, count, in_ready);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, XOR, 32'h680 + 32'(i * 4)); cycle();
        end
        rdy = 1'b0; ROB_full = 1'b0;
        drive(1'b1, ADD, 32'h700);
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (count !== 5'd3 || out_pc !== 32'h680) begin
                errors++; $display("FAIL rdy_hold%0d got count=%0d pc=%h want 3/00000680", i, count, out_pc);
            end
        end
        rdy = 1'b1;
        drive(1'b0, ADD, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sb.size() == 0 || out_pc !== sb[0].pc || out_optype !== XOR) begin
                errors++; $display("FAIL rdy_drain%0d got pc=%h op=%0d want %h/%0d", i, out_pc, out_optype,
                                   32'h680 + 32'(i * 4), XOR);
            end
            cycle();
        end
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL rdy_drain_empty got count=%0d want 0", count); end
    endtask

    task automatic test_bypass();
        ROB_full = 1'b0; RS_full = 1'b0; LSB_full = 1'b0;
        drive(1'b1, ADD, 32'h40);
        #1;
`ifdef IQ_BYPASS_EN
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
            errors++; $display("FAIL bypass_same_cycle got v=%b pc=%h want 1/00000040", out_valid, out_pc);
        end
        cycle();
        checks++;
        if (count !== 5'(sb.size()) || count !== 5'd0) begin
            errors++; $display("FAIL bypass_count got count=%0d want 0", count);
        end
`else
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL empty_no_bypass got v=%b want 0", out_valid);
        end
        cycle();
        checks++;
        if (count !== 5'(sb.size()) || count !== 5'd1 || out_pc !== 32'h40) begin
            errors++; $display("FAIL empty_push got count=%0d pc=%h want 1/00000040", count, out_pc);
        end
`endif
        drive(1'b0, ADD, 32'h0);
        cycle();
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_full();
        test_dispatch_stall();
        test_flush();
        test_async_reset_and_rdy();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
